// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 valid/ready stream demultiplexer.
package demux_pkg;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot for a single demux channel.
module demux_out_slot #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         pop_ready,
    output logic         valid,
    output logic [W-1:0] q
);

    // A load takes priority over a pop in the same cycle, so the slot never bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Routes one valid/ready stream to one of four registered output slots.
// Define DEMUX_RR_EN to route by a round-robin pointer instead of in_sel.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3
);

    sel_t               dst;
    logic               accept;
    logic [N_OUT-1:0]   load;
    logic [W-1:0]       slot_q [N_OUT];

`ifdef DEMUX_RR_EN
    sel_t rr_ptr;
    logic unused_sel;

    assign unused_sel = ^in_sel;
    assign dst        = rr_ptr;

    // Pointer only advances on an accepted word, so a full channel stalls the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end
`else
    assign dst = in_sel;
`endif

    assign in_ready = !out_valid[dst] || out_ready[dst];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            load[i] = accept && (dst == sel_t'(i));
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_out_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .d         (in_data),
            .pop_ready (out_ready[i]),
            .valid     (out_valid[i]),
            .q         (slot_q[i])
        );
    end

    assign out_data0 = slot_q[0];
    assign out_data1 = slot_q[1];
    assign out_data2 = slot_q[2];
    assign out_data3 = slot_q[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Table-driven directed bench for demux_1_4_stream; DEMUX_RR_EN selects the round-robin table.
module tb_demux_1_4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] out_data0, out_data1, out_data2, out_data3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_1_4_stream #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] sel;
        logic [3:0] d;
        logic [3:0] ordy;
        logic       chk_rdy;
        logic       rdy;
        logic [3:0] ov;
        logic [3:0] d0, d1, d2, d3;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [1:0] sel, logic [3:0] d, logic [3:0] ordy,
                                logic chk_rdy, logic rdy, logic [3:0] ov,
                                logic [3:0] d0, logic [3:0] d1, logic [3:0] d2, logic [3:0] d3);
        vec_t t;
        t.rst = r; t.v = v; t.sel = sel; t.d = d; t.ordy = ordy;
        t.chk_rdy = chk_rdy; t.rdy = rdy; t.ov = ov;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.d3 = d3;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;

        // rst v sel d ordy | chk rdy | ov d0 d1 d2 d3
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, 0));
`ifndef DEMUX_RR_EN
        // routing, one word per channel, one valid bit at a time
        tbl.push_back(mk(0, 1, 0, 4'hA, 4'b1111, 1, 1, 4'b0001, 4'hA, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'hB, 4'b1111, 1, 1, 4'b0010, 4'hA, 4'hB, 0, 0));
        tbl.push_back(mk(0, 1, 2, 4'hC, 4'b1111, 1, 1, 4'b0100, 4'hA, 4'hB, 4'hC, 0));
        tbl.push_back(mk(0, 1, 3, 4'hD, 4'b1111, 1, 1, 4'b1000, 4'hA, 4'hB, 4'hC, 4'hD));
        tbl.push_back(mk(0, 0, 3, 4'h0, 4'b1111, 1, 1, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD));
        // back-pressure on channel 2, then pop+load with no bubble
        tbl.push_back(mk(0, 1, 2, 4'h5, 4'b1011, 1, 1, 4'b0100, 4'hA, 4'hB, 4'h5, 4'hD));
        tbl.push_back(mk(0, 1, 2, 4'h6, 4'b1011, 1, 0, 4'b0100, 4'hA, 4'hB, 4'h5, 4'hD));
        tbl.push_back(mk(0, 1, 2, 4'h6, 4'b1111, 1, 1, 4'b0100, 4'hA, 4'hB, 4'h6, 4'hD));
        tbl.push_back(mk(0, 0, 2, 4'h0, 4'b1111, 1, 1, 4'b0000, 4'hA, 4'hB, 4'h6, 4'hD));
        // channel 1 stalled does not block channel 3
        tbl.push_back(mk(0, 1, 1, 4'h7, 4'b1101, 1, 1, 4'b0010, 4'hA, 4'h7, 4'h6, 4'hD));
        tbl.push_back(mk(0, 1, 1, 4'h8, 4'b1101, 1, 0, 4'b0010, 4'hA, 4'h7, 4'h6, 4'hD));
        tbl.push_back(mk(0, 1, 3, 4'h9, 4'b1101, 1, 1, 4'b1010, 4'hA, 4'h7, 4'h6, 4'h9));
        tbl.push_back(mk(0, 0, 3, 4'h0, 4'b1101, 1, 1, 4'b0010, 4'hA, 4'h7, 4'h6, 4'h9));
        // fill every slot, then reset mid-operation
        tbl.push_back(mk(0, 1, 0, 4'h1, 4'b0000, 1, 1, 4'b0011, 4'h1, 4'h7, 4'h6, 4'h9));
        tbl.push_back(mk(0, 1, 2, 4'h2, 4'b0000, 1, 1, 4'b0111, 4'h1, 4'h7, 4'h2, 4'h9));
        tbl.push_back(mk(0, 1, 3, 4'h3, 4'b0000, 1, 1, 4'b1111, 4'h1, 4'h7, 4'h2, 4'h3));
        tbl.push_back(mk(0, 1, 0, 4'h4, 4'b0000, 1, 0, 4'b1111, 4'h1, 4'h7, 4'h2, 4'h3));
        tbl.push_back(mk(1, 1, 0, 4'h4, 4'b1111, 1, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 4'b1111, 1, 1, 4'b0000, 0, 0, 0, 0));
`else
        // in_sel held at 0; pointer walks 0,1,2,3,0
        tbl.push_back(mk(0, 1, 0, 4'h1, 4'b1111, 1, 1, 4'b0001, 4'h1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h2, 4'b1111, 1, 1, 4'b0010, 4'h1, 4'h2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h3, 4'b1111, 1, 1, 4'b0100, 4'h1, 4'h2, 4'h3, 0));
        tbl.push_back(mk(0, 1, 0, 4'h4, 4'b1111, 1, 1, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4));
        tbl.push_back(mk(0, 1, 0, 4'h5, 4'b1111, 1, 1, 4'b0001, 4'h5, 4'h2, 4'h3, 4'h4));
        // channel 1 stalled: pointer must hold at 1 until it drains
        tbl.push_back(mk(0, 1, 0, 4'h6, 4'b1101, 1, 1, 4'b0010, 4'h5, 4'h6, 4'h3, 4'h4));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'b1101, 1, 1, 4'b0110, 4'h5, 4'h6, 4'h7, 4'h4));
        tbl.push_back(mk(0, 1, 0, 4'h8, 4'b1101, 1, 1, 4'b1010, 4'h5, 4'h6, 4'h7, 4'h8));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'b1101, 1, 1, 4'b0011, 4'h9, 4'h6, 4'h7, 4'h8));
        tbl.push_back(mk(0, 1, 0, 4'hA, 4'b1101, 1, 0, 4'b0010, 4'h9, 4'h6, 4'h7, 4'h8));
        tbl.push_back(mk(0, 1, 0, 4'hA, 4'b1101, 1, 0, 4'b0010, 4'h9, 4'h6, 4'h7, 4'h8));
        tbl.push_back(mk(0, 1, 0, 4'hA, 4'b1111, 1, 1, 4'b0010, 4'h9, 4'hA, 4'h7, 4'h8));
        tbl.push_back(mk(0, 1, 0, 4'hB, 4'b1111, 1, 1, 4'b0100, 4'h9, 4'hA, 4'hB, 4'h8));
`endif

        foreach (tbl[i]) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].v;
            in_sel    = tbl[i].sel;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            if (tbl[i].chk_rdy) check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("row%0d out_data0", i), 32'(out_data0), 32'(tbl[i].d0));
            check($sformatf("row%0d out_data1", i), 32'(out_data1), 32'(tbl[i].d1));
            check($sformatf("row%0d out_data2", i), 32'(out_data2), 32'(tbl[i].d2));
            check($sformatf("row%0d out_data3", i), 32'(out_data3), 32'(tbl[i].d3));
        end

        // Hand sequence: park a word in a stalled slot, then release and wait for it to drain.
        rst = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hE; out_ready = 4'b0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("park out_valid", 32'(out_valid != 4'b0000), 32'(1));
        out_ready = 4'b1111;
        begin
            int budget;
            budget = 8;
            while (out_valid != 4'b0000 && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            check("drain within budget", 32'(budget > 0), 32'(1));
            check("drain out_valid", 32'(out_valid), 32'(0));
        end
        #1;
        check("idle in_ready", 32'(in_ready), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
